// File: rtl/player_move_arbiter.sv
// player_move_arbiter: sequences both players' move/attack requests onto the tile map.
// Arbitrates A vs B round-robin, validates each move against walkAble, the map bounds
// and the other player's tile, and owns both players' tile registers and attack pulses.
// Optional feature: define ATK_COOLDOWN_EN to add a per-player attack cooldown (ATK_GAP).
module player_move_arbiter #(
    parameter int unsigned HMAXTILE  = 9,
    parameter int unsigned VMAXTILE  = 5,
    parameter int unsigned A_START_H = 0,
    parameter int unsigned A_START_V = 0,
    parameter int unsigned B_START_H = 9,
    parameter int unsigned B_START_V = 5,
    parameter logic [25:0] MOVE_GAP  = 26'd12_500_000,
    parameter logic [25:0] ATK_GAP   = 26'd50_000_000
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   reqA_vld,
    input  logic [1:0]                             reqA_dir,
    input  logic                                   reqA_atk,
    input  logic                                   reqB_vld,
    input  logic [1:0]                             reqB_dir,
    input  logic                                   reqB_atk,
    input  logic [(HMAXTILE+1)*(VMAXTILE+1):0]     walkAble,
    output logic [3:0]                             curAh,
    output logic [3:0]                             curAv,
    output logic [3:0]                             curBh,
    output logic [3:0]                             curBv,
    output logic                                   atkFromA,
    output logic                                   atkFromB,
    output logic                                   doneA,
    output logic                                   doneB,
    output logic                                   rejA,
    output logic                                   rejB
);

    localparam int unsigned ROW_W  = HMAXTILE + 1;
    localparam int unsigned WALK_W = ROW_W * (VMAXTILE + 1) + 1;
    localparam int unsigned IDX_W  = $clog2(WALK_W);
    localparam int unsigned CD_W   = 26;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_CHECK  = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    // Arbiter state; srv/rr_ptr encode the side: 0 = A, 1 = B
    state_t state;
    state_t state_nxt;
    logic   srv;
    logic   srv_nxt;
    logic   rr_ptr;
    logic   rr_nxt;

    // Pending request and move cooldown per player
    logic            pend_a;
    logic            pend_a_atk;
    logic [1:0]      pend_a_dir;
    logic            pend_b;
    logic            pend_b_atk;
    logic [1:0]      pend_b_dir;
    logic [CD_W-1:0] mcd_a;
    logic [CD_W-1:0] mcd_b;

`ifdef ATK_COOLDOWN_EN
    logic [CD_W-1:0] acd_a;
    logic [CD_W-1:0] acd_b;
`else
    // ATK_GAP only has a consumer when the attack cooldown is built in
    logic unused_atk_gap;
    assign unused_atk_gap = ^ATK_GAP;
`endif

    // Capture-side decode
    logic busy_a_c;
    logic busy_b_c;
    logic mhit_a_c;
    logic mhit_b_c;
    logic ahit_a_c;
    logic ahit_b_c;
    logic take_a_c;
    logic take_b_c;

    // Validation of the served request
    logic [3:0]       src_h_c;
    logic [3:0]       src_v_c;
    logic [3:0]       oth_h_c;
    logic [3:0]       oth_v_c;
    logic [3:0]       tgt_h_c;
    logic [3:0]       tgt_v_c;
    logic [1:0]       src_dir_c;
    logic [IDX_W-1:0] idx_c;
    logic             edge_c;
    logic             wall_c;
    logic             occ_c;
    logic             bad_c;
    logic             commit_c;
    logic             fin_a_c;
    logic             fin_b_c;
    logic             move_a_c;
    logic             move_b_c;
    logic             atk_a_c;
    logic             atk_b_c;

    // Arbiter state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            srv    <= 1'b0;
            rr_ptr <= 1'b0;
        end else begin
            state  <= state_nxt;
            srv    <= srv_nxt;
            rr_ptr <= rr_nxt;
        end
    end

    // Arbiter next state: grant picks the side, then fixed CHECK -> COMMIT -> IDLE walk
    always_comb begin
        state_nxt = state;
        srv_nxt   = srv;
        rr_nxt    = rr_ptr;
        case (state)
            S_IDLE: begin
                if (pend_a || pend_b) begin
                    state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (pend_a && pend_b) begin
                    srv_nxt   = rr_ptr;
                    rr_nxt    = ~rr_ptr;
                    state_nxt = S_CHECK;
                end else if (pend_a || pend_b) begin
                    srv_nxt   = pend_b;
                    state_nxt = S_CHECK;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_CHECK:  state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Strobe classification: dropped while in service, cooldown-refused, or latched
    always_comb begin
        busy_a_c = ((state == S_CHECK) || (state == S_COMMIT)) && !srv;
        busy_b_c = ((state == S_CHECK) || (state == S_COMMIT)) && srv;
        mhit_a_c = reqA_vld && !busy_a_c && !reqA_atk && (mcd_a != '0);
        mhit_b_c = reqB_vld && !busy_b_c && !reqB_atk && (mcd_b != '0);
        ahit_a_c = 1'b0;
        ahit_b_c = 1'b0;
`ifdef ATK_COOLDOWN_EN
        ahit_a_c = reqA_vld && !busy_a_c && reqA_atk && (acd_a != '0);
        ahit_b_c = reqB_vld && !busy_b_c && reqB_atk && (acd_b != '0);
`endif
        take_a_c = reqA_vld && !busy_a_c && !mhit_a_c && !ahit_a_c;
        take_b_c = reqB_vld && !busy_b_c && !mhit_b_c && !ahit_b_c;
    end

    // Target tile and legality of the served side's pending move
    always_comb begin
        src_h_c   = srv ? curBh : curAh;
        src_v_c   = srv ? curBv : curAv;
        oth_h_c   = srv ? curAh : curBh;
        oth_v_c   = srv ? curAv : curBv;
        src_dir_c = srv ? pend_b_dir : pend_a_dir;
        tgt_h_c   = src_h_c;
        tgt_v_c   = src_v_c;
        edge_c    = 1'b0;
        case (src_dir_c)
            2'd0: begin
                if (src_v_c == 4'd0) edge_c = 1'b1;
                else                 tgt_v_c = src_v_c - 4'd1;
            end
            2'd1: begin
                if (src_v_c >= 4'(VMAXTILE)) edge_c = 1'b1;
                else                         tgt_v_c = src_v_c + 4'd1;
            end
            2'd2: begin
                if (src_h_c == 4'd0) edge_c = 1'b1;
                else                 tgt_h_c = src_h_c - 4'd1;
            end
            default: begin
                if (src_h_c >= 4'(HMAXTILE)) edge_c = 1'b1;
                else                         tgt_h_c = src_h_c + 4'd1;
            end
        endcase
        idx_c    = IDX_W'(ROW_W * 32'(tgt_v_c) + 32'(tgt_h_c));
        wall_c   = !walkAble[idx_c];
        occ_c    = (tgt_h_c == oth_h_c) && (tgt_v_c == oth_v_c);
        bad_c    = edge_c || wall_c || occ_c;
        commit_c = (state == S_CHECK);
        fin_a_c  = commit_c && !srv;
        fin_b_c  = commit_c && srv;
        move_a_c = fin_a_c && !pend_a_atk && !bad_c;
        move_b_c = fin_b_c && !pend_b_atk && !bad_c;
        atk_a_c  = fin_a_c && pend_a_atk;
        atk_b_c  = fin_b_c && pend_b_atk;
    end

    // Player A: pending request, position, move cooldown and retire pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            curAh      <= 4'(A_START_H);
            curAv      <= 4'(A_START_V);
            pend_a     <= 1'b0;
            pend_a_dir <= 2'd0;
            pend_a_atk <= 1'b0;
            mcd_a      <= '0;
            doneA      <= 1'b0;
            rejA       <= 1'b0;
            atkFromA   <= 1'b0;
        end else begin
            doneA    <= mhit_a_c || ahit_a_c || fin_a_c;
            rejA     <= mhit_a_c || ahit_a_c || (fin_a_c && !pend_a_atk && bad_c);
            atkFromA <= atk_a_c;
            if (fin_a_c) begin
                pend_a <= 1'b0;
            end else if (take_a_c) begin
                pend_a     <= 1'b1;
                pend_a_dir <= reqA_dir;
                pend_a_atk <= reqA_atk;
            end
            if (move_a_c) begin
                curAh <= tgt_h_c;
                curAv <= tgt_v_c;
            end
            if (move_a_c)          mcd_a <= MOVE_GAP;
            else if (mcd_a != '0)  mcd_a <= mcd_a - CD_W'(1);
        end
    end

    // Player B: pending request, position, move cooldown and retire pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            curBh      <= 4'(B_START_H);
            curBv      <= 4'(B_START_V);
            pend_b     <= 1'b0;
            pend_b_dir <= 2'd0;
            pend_b_atk <= 1'b0;
            mcd_b      <= '0;
            doneB      <= 1'b0;
            rejB       <= 1'b0;
            atkFromB   <= 1'b0;
        end else begin
            doneB    <= mhit_b_c || ahit_b_c || fin_b_c;
            rejB     <= mhit_b_c || ahit_b_c || (fin_b_c && !pend_b_atk && bad_c);
            atkFromB <= atk_b_c;
            if (fin_b_c) begin
                pend_b <= 1'b0;
            end else if (take_b_c) begin
                pend_b     <= 1'b1;
                pend_b_dir <= reqB_dir;
                pend_b_atk <= reqB_atk;
            end
            if (move_b_c) begin
                curBh <= tgt_h_c;
                curBv <= tgt_v_c;
            end
            if (move_b_c)          mcd_b <= MOVE_GAP;
            else if (mcd_b != '0)  mcd_b <= mcd_b - CD_W'(1);
        end
    end

`ifdef ATK_COOLDOWN_EN
    // Attack cooldowns: reload on an issued attack, count down to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            acd_a <= '0;
            acd_b <= '0;
        end else begin
            if (atk_a_c)           acd_a <= ATK_GAP;
            else if (acd_a != '0)  acd_a <= acd_a - CD_W'(1);
            if (atk_b_c)           acd_b <= ATK_GAP;
            else if (acd_b != '0)  acd_b <= acd_b - CD_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_player_move_arbiter.sv
// Directed bench for player_move_arbiter with a retire scoreboard (MOVE_GAP=4, ATK_GAP=8).
module tb_player_move_arbiter;

    localparam int ROW  = 10;
    localparam int HMAX = 9;
    localparam int VMAX = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqA_vld;
    logic [1:0]  reqA_dir;
    logic        reqA_atk;
    logic        reqB_vld;
    logic [1:0]  reqB_dir;
    logic        reqB_atk;
    logic [60:0] walk;
    logic [3:0]  curAh;
    logic [3:0]  curAv;
    logic [3:0]  curBh;
    logic [3:0]  curBv;
    logic        atkFromA;
    logic        atkFromB;
    logic        doneA;
    logic        doneB;
    logic        rejA;
    logic        rejB;

    player_move_arbiter #(
        .HMAXTILE (9),
        .VMAXTILE (5),
        .A_START_H(0),
        .A_START_V(0),
        .B_START_H(9),
        .B_START_V(5),
        .MOVE_GAP (26'd4),
        .ATK_GAP  (26'd8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .reqA_vld (reqA_vld),
        .reqA_dir (reqA_dir),
        .reqA_atk (reqA_atk),
        .reqB_vld (reqB_vld),
        .reqB_dir (reqB_dir),
        .reqB_atk (reqB_atk),
        .walkAble (walk),
        .curAh    (curAh),
        .curAv    (curAv),
        .curBh    (curBh),
        .curBv    (curBv),
        .atkFromA (atkFromA),
        .atkFromB (atkFromB),
        .doneA    (doneA),
        .doneB    (doneB),
        .rejA     (rejA),
        .rejB     (rejB)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit sb;
        bit rej;
        bit atk;
        int h;
        int v;
        int due;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   ah, av, bh, bv;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input integer obs, input integer exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the retiring side
    task automatic retire(input bit sb);
        exp_t  e;
        string s;
        s = sb ? "B" : "A";
        check({s, "_done_expected"}, integer'(sbq.size() > 0), 1);
        if (sbq.size() == 0) return;
        e = sbq.pop_front();
        check({s, "_side"},       integer'(sb), integer'(e.sb));
        check({s, "_done_cycle"}, cyc, e.due);
        check({s, "_rej"},        sb ? rejB : rejA, integer'(e.rej));
        check({s, "_atk"},        sb ? atkFromB : atkFromA, integer'(e.atk));
        check({s, "_h"},          sb ? curBh : curAh, e.h);
        check({s, "_v"},          sb ? curBv : curAv, e.v);
    endtask

    always @(negedge clk) begin
        if (doneA) retire(1'b0);
        if (doneB) retire(1'b1);
        if (atkFromA) check("atkA_with_doneA", doneA, 1);
        if (atkFromB) check("atkB_with_doneB", doneB, 1);
    end

    // Expected outcome from the bench's own position model
    task automatic push_exp(input bit sb, input int dir, input bit atk, input bit cd_rej, input int lat);
        exp_t e;
        int h, v, oh, ov, nh, nv;
        bit bad;
        h  = sb ? bh : ah;
        v  = sb ? bv : av;
        oh = sb ? ah : bh;
        ov = sb ? av : bv;
        e.sb  = sb;
        e.atk = atk && !cd_rej;
        e.rej = cd_rej;
        if (!atk && !cd_rej) begin
            nh = h; nv = v; bad = 1'b0;
            case (dir)
                0: if (v == 0)    bad = 1'b1; else nv = v - 1;
                1: if (v == VMAX) bad = 1'b1; else nv = v + 1;
                2: if (h == 0)    bad = 1'b1; else nh = h - 1;
                default: if (h == HMAX) bad = 1'b1; else nh = h + 1;
            endcase
            if (!bad && walk[6'(ROW * nv + nh)] == 1'b0) bad = 1'b1;
            if (!bad && nh == oh && nv == ov) bad = 1'b1;
            if (!bad) begin h = nh; v = nv; end
            e.rej = bad;
        end
        if (sb) begin bh = h; bv = v; end
        else    begin ah = h; av = v; end
        e.h   = h;
        e.v   = v;
        e.due = cyc + lat;
        sbq.push_back(e);
    endtask

    task automatic drive(input bit ua, input int da, input bit aa, input bit ub, input int db, input bit ab);
        reqA_vld = ua; reqA_dir = 2'(da); reqA_atk = aa;
        reqB_vld = ub; reqB_dir = 2'(db); reqB_atk = ab;
        @(negedge clk);
        reqA_vld = 1'b0; reqB_vld = 1'b0;
        reqA_atk = 1'b0; reqB_atk = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("retired_in_time", sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic step(input bit sb, input int dir, input bit atk);
        push_exp(sb, dir, atk, 1'b0, 4);
        if (sb) drive(1'b0, 0, 1'b0, 1'b1, dir, atk);
        else    drive(1'b1, dir, atk, 1'b0, 0, 1'b0);
        drain();
        idle(6);
    endtask

    task automatic check_home(input string tag);
        check({tag, "_curAh"}, curAh, 0);
        check({tag, "_curAv"}, curAv, 0);
        check({tag, "_curBh"}, curBh, 9);
        check({tag, "_curBv"}, curBv, 5);
        check({tag, "_pulses"}, {atkFromA, atkFromB, doneA, doneB, rejA, rejB}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst = 1'b1;
        reqA_vld = 1'b0; reqA_dir = 2'd0; reqA_atk = 1'b0;
        reqB_vld = 1'b0; reqB_dir = 2'd0; reqB_atk = 1'b0;
        walk = '1;
        ah = 0; av = 0; bh = 9; bv = 5;
        repeat (2) @(negedge clk);
        check_home("reset");
        rst = 1'b0;
        idle(2);

        // basic move and latency
        step(1'b0, 3, 1'b0);
        // map edges at (0,0) and at (9,5)
        step(1'b0, 2, 1'b0);
        step(1'b0, 0, 1'b0);
        step(1'b0, 2, 1'b0);
        step(1'b1, 3, 1'b0);
        step(1'b1, 1, 1'b0);
        // wall
        walk[1] = 1'b0;
        step(1'b0, 3, 1'b0);
        walk = '1;
        // walk B to (1,0), then both try to enter the other's tile
        repeat (5) step(1'b1, 0, 1'b0);
        repeat (8) step(1'b1, 2, 1'b0);
        step(1'b0, 3, 1'b0);
        step(1'b1, 2, 1'b0);

        // simultaneous requests: A first, then B first
        push_exp(1'b0, 1, 1'b0, 1'b0, 4);
        push_exp(1'b1, 1, 1'b0, 1'b0, 8);
        drive(1'b1, 1, 1'b0, 1'b1, 1, 1'b0);
        drain();
        idle(6);
        push_exp(1'b1, 1, 1'b0, 1'b0, 4);
        push_exp(1'b0, 1, 1'b0, 1'b0, 8);
        drive(1'b1, 1, 1'b0, 1'b1, 1, 1'b0);
        drain();
        idle(6);

        // move cooldown: refused 2 cycles after retire, accepted 5 cycles after
        t0 = cyc;
        push_exp(1'b0, 1, 1'b0, 1'b0, 4);
        drive(1'b1, 1, 1'b0, 1'b0, 0, 1'b0);
        wait_until(t0 + 6);
        push_exp(1'b0, 1, 1'b0, 1'b1, 1);
        drive(1'b1, 1, 1'b0, 1'b0, 0, 1'b0);
        wait_until(t0 + 9);
        push_exp(1'b0, 1, 1'b0, 1'b0, 4);
        drive(1'b1, 1, 1'b0, 1'b0, 0, 1'b0);
        drain();
        idle(6);

        // two attacks from B, the second 2 cycles after the first retires
        t0 = cyc;
        push_exp(1'b1, 0, 1'b1, 1'b0, 4);
        drive(1'b0, 0, 1'b0, 1'b1, 0, 1'b1);
        wait_until(t0 + 6);
`ifdef ATK_COOLDOWN_EN
        push_exp(1'b1, 0, 1'b1, 1'b1, 1);
`else
        push_exp(1'b1, 0, 1'b1, 1'b0, 4);
`endif
        drive(1'b0, 0, 1'b0, 1'b1, 0, 1'b1);
        drain();
        idle(10);

        // reset while A's request is in CHECK: no retire, everything back home
        t0 = cyc;
        drive(1'b1, 3, 1'b0, 1'b0, 0, 1'b0);
        wait_until(t0 + 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_home("midreset");
        ah = 0; av = 0; bh = 9; bv = 5;
        idle(10);
        step(1'b0, 3, 1'b0);

        check("scoreboard_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
